wb_stage: RTL
=============

# wb_stage

Writeback stage of the 16-bit pipeline: holds the MEM/WB pipeline register, selects the writeback value (ALU result or load data), and drives the register-bank write port consumed by instruction decode (`WB`, `WriteRegister`, `RegWrite`). It also provides write-through bypass for decode's two read operands, so a register written this cycle is seen by the instruction being decoded this cycle. It also exports the in-flight writeback to the EX-stage forwarding unit.

## Interface
Parameters:
- `DATA_W`, 16, datapath width.
- `REG_W`, 3, register index width (8 registers; r0 hardwired to zero).

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold the MEM/WB register contents.
- `flush` in 1: load a bubble into MEM/WB.
- `valid_in` in 1: MEM stage presents a real instruction.
- `RegWrite_in` in 1: instruction writes a register.
- `MemtoReg_in` in 1: 1 = write `mem_data`, 0 = write `alu_result`.
- `WriteRegister_in` in REG_W: destination register.
- `alu_result` in DATA_W: ALU result from MEM.
- `mem_data` in DATA_W: load data from data memory.
- `rs_id`, `rt_id` in REG_W: decode read indices.
- `dado1_bank`, `dado2_bank` in DATA_W: raw register-bank read data.
- `WB` out DATA_W: write data to register bank.
- `WriteRegister` out REG_W: write index to register bank.
- `RegWrite` out 1: write enable to register bank.
- `dado1_id`, `dado2_id` out DATA_W: bypassed operands to the ID/EX register.
- `fw_valid` out 1, `fw_reg` out REG_W, `fw_data` out DATA_W: forwarding source for EX.
- `retired` out 16: retired-instruction count (only with `WB_RETIRE_COUNT_EN`).

## Operation
- MEM/WB register fields: valid, RegWrite, WriteRegister, selected data. The selected data is `MemtoReg_in ? mem_data : alu_result`, computed before the register.
- Update priority each edge: reset > flush > stall > load.
  - Reset and flush: valid=0, RegWrite=0, WriteRegister=0, data=0.
  - Stall: all fields hold.
  - Load: capture the inputs.
- Effective write enable: `RegWrite = valid & RegWrite_q & (WriteRegister != 0)`. Writes to r0 are suppressed, but valid still counts as retired.
- `WB` and `WriteRegister` always show the registered data and index, even when `RegWrite` = 0.
- Bypass (combinational from registered state):
  - `dado1_id = (RegWrite && WriteRegister==rs_id) ? WB : dado1_bank`.
  - `dado2_id` uses `rt_id` and `dado2_bank` the same way.
  - If `rs_id`==0 or `rt_id`==0, the matching output is forced to 0, regardless of bank data.
- Forwarding: `fw_valid = RegWrite`, `fw_reg = WriteRegister`, `fw_data = WB`.
- During stall, held outputs keep asserting `RegWrite`. Rewriting the same value is idempotent and is the required behaviour.

## Timing
- Latency: inputs sampled at edge N appear on `WB`/`WriteRegister`/`RegWrite` after edge N, for one cycle, or longer if stalled.
- The register bank writes at edge N+1. The bypass covers decode reads in the cycle between edges N and N+1.
- Reset values: `WB`=0, `WriteRegister`=0, `RegWrite`=0, `fw_valid`=0, `fw_reg`=0, `fw_data`=0, `retired`=0.
- `dado1_id`/`dado2_id` have no reset value. They are combinational: after reset they pass the bank data, and are 0 when the index is 0.
- `flush` and `stall` together: flush wins and a bubble loads.
- Reset asserted mid-stall: state clears on that edge, and the stall is ignored until reset deasserts.
- `valid_in`=0 with `RegWrite_in`=1 loads a bubble-equivalent (no write, not retired).

## Configuration
- Macro `WB_RETIRE_COUNT_EN`.
- Defined:
  - `retired` is a 16-bit counter; reset sets it to 0.
  - It increments on each edge where valid is set, not stalled, and not in reset; stalled cycles count once.
  - It wraps 0xFFFF→0x0000.
- Undefined: the `retired` port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `wb_pkg`:
  - constants `DATA_W`=16, `REG_W`=3, `REG_ZERO`=3'd0;
  - a packed typedef `memwb_t` {valid, regwrite, wreg, data}.
- One natural sub-module, `wb_bypass`: a pure combinational compare/mux for one operand, instantiated twice (rs and rt).

## Test plan
- Reset: hold `reset` 2 cycles with random inputs → all outputs 0 and `RegWrite`=0; with `rs_id`=0, `dado1_id`=0.
- ALU writeback: load `alu_result`=0x1234, `MemtoReg_in`=0, `WriteRegister_in`=3, valid → the next cycle shows `WB`=0x1234, `WriteRegister`=3, `RegWrite`=1.
- Load writeback: `mem_data`=0xBEEF, `MemtoReg_in`=1, `alu_result`=0x0004, reg 5 → `WB`=0xBEEF.
- Bypass and r0 suppression:
  - with reg 5 held, `rs_id`=5, `dado1_bank`=0x0000 → `dado1_id`=0xBEEF;
  - `rt_id`=2, `dado2_bank`=0x00AA → `dado2_id`=0x00AA;
  - writing reg 0 with 0x7777 → `RegWrite`=0.
- Stall/flush: stall 3 cycles after loading reg 6 → outputs hold 3 cycles; then flush and stall together → `RegWrite`=0 and `WB`=0 the next cycle.
- With `WB_RETIRE_COUNT_EN`: preload `retired` via 0xFFFF valid retirements, then one more → `retired`=0x0000. Stall/bubble cycles do not increment it.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage of the 16-bit pipeline.
package wb_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } memwb_t;
endpackage

// File: rtl/wb_bypass.sv
// Write-through bypass for one decode read operand; r0 always reads as zero.
module wb_bypass #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic [REG_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] bank_data,
  input  logic              wr_en,
  input  logic [REG_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
  import wb_pkg::*;

  always_comb begin
    rd_data = bank_data;
    if (rd_idx == REG_ZERO)
      rd_data = '0;
    else if (wr_en && (wr_idx == rd_idx))
      rd_data = wr_data;
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback select, register-bank write port,
// decode bypass and EX forwarding source. Optional retire counter: WB_RETIRE_COUNT_EN.
module wb_stage #(
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int REG_W  = wb_pkg::REG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              RegWrite_in,
  input  logic              MemtoReg_in,
  input  logic [REG_W-1:0]  WriteRegister_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_W-1:0]  rs_id,
  input  logic [REG_W-1:0]  rt_id,
  input  logic [DATA_W-1:0] dado1_bank,
  input  logic [DATA_W-1:0] dado2_bank,
  output logic [DATA_W-1:0] WB,
  output logic [REG_W-1:0]  WriteRegister,
  output logic              RegWrite,
  output logic [DATA_W-1:0] dado1_id,
  output logic [DATA_W-1:0] dado2_id,
  output logic              fw_valid,
  output logic [REG_W-1:0]  fw_reg,
  output logic [DATA_W-1:0] fw_data
`ifdef WB_RETIRE_COUNT_EN
  , output logic [15:0]     retired
`endif
);
  import wb_pkg::*;

  memwb_t memwb_p0;
  memwb_t memwb_p1;
  logic   we_p1;

  // MEM side: writeback value is selected before the register
  always_comb begin
    memwb_p0.valid    = valid_in;
    memwb_p0.regwrite = RegWrite_in;
    memwb_p0.wreg     = WriteRegister_in;
    memwb_p0.data     = MemtoReg_in ? mem_data : alu_result;
  end

  // MEM/WB boundary: flush beats stall so a squashed slot never lingers
  always_ff @(posedge clock) begin
    if (reset || flush)
      memwb_p1 <= '0;
    else if (!stall)
      memwb_p1 <= memwb_p0;
  end

  // WB side: writes to r0 are dropped but the instruction still retires
  assign we_p1         = memwb_p1.valid & memwb_p1.regwrite & (memwb_p1.wreg != REG_ZERO);
  assign WB            = memwb_p1.data;
  assign WriteRegister = memwb_p1.wreg;
  assign RegWrite      = we_p1;

  assign fw_valid = we_p1;
  assign fw_reg   = memwb_p1.wreg;
  assign fw_data  = memwb_p1.data;

  wb_bypass #(.DATA_W(DATA_W), .REG_W(REG_W)) u_bypass_rs (
    .rd_idx    (rs_id),
    .bank_data (dado1_bank),
    .wr_en     (we_p1),
    .wr_idx    (memwb_p1.wreg),
    .wr_data   (memwb_p1.data),
    .rd_data   (dado1_id)
  );

  wb_bypass #(.DATA_W(DATA_W), .REG_W(REG_W)) u_bypass_rt (
    .rd_idx    (rt_id),
    .bank_data (dado2_bank),
    .wr_en     (we_p1),
    .wr_idx    (memwb_p1.wreg),
    .wr_data   (memwb_p1.data),
    .rd_data   (dado2_id)
  );

`ifdef WB_RETIRE_COUNT_EN
  logic [15:0] retired_p1;

  // A stalled instruction is counted once, on the edge it finally leaves WB
  always_ff @(posedge clock) begin
    if (reset)
      retired_p1 <= '0;
    else if (memwb_p1.valid && !stall)
      retired_p1 <= retired_p1 + 16'd1;
  end

  assign retired = retired_p1;
`endif
endmodule
